// File: rtl/asconp_iter_lut_if.sv
// Request/response/LUT-programming bundle for asconp_iter_lut.
// The optional sbox_rdata_o signal exists only with ASCONP_SBOX_READBACK_EN.
interface asconp_iter_lut_if;
  logic        start_i;
  logic [3:0]  rounds_i;
  logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
  logic        ready_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
  logic        cfg_err_o;
  logic        sbox_we_i;
  logic [4:0]  sbox_addr_i;
  logic [4:0]  sbox_wdata_i;
`ifdef ASCONP_SBOX_READBACK_EN
  logic [4:0]  sbox_rdata_o;
`endif

  modport slave (
    input  start_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
           sbox_we_i, sbox_addr_i, sbox_wdata_i,
    output ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o, cfg_err_o
`ifdef ASCONP_SBOX_READBACK_EN
    , output sbox_rdata_o
`endif
  );

  modport master (
    output start_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
           sbox_we_i, sbox_addr_i, sbox_wdata_i,
    input  ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o, cfg_err_o
`ifdef ASCONP_SBOX_READBACK_EN
    , input sbox_rdata_o
`endif
  );
endinterface

// File: rtl/asconp_iter_lut.sv
// Iterative Ascon-p engine, UROL rounds per clock, runtime-programmable S-box LUT.
// Optional macro ASCONP_SBOX_READBACK_EN adds combinational LUT readback.

// One bit-column S-box lookup (column bit 4 = x0).
module asconp_sbox_lane (
  input  logic [31:0][4:0] i_lut,
  input  logic [4:0]       i_col,
  output logic [4:0]       o_sb
);
  assign o_sb = i_lut[i_col];
endmodule

// One full Ascon round: constant add, LUT substitution, linear diffusion.
module asconp_round (
  input  logic [4:0][63:0] i_x,
  input  logic [3:0]       i_r,
  input  logic [31:0][4:0] i_lut,
  output logic [4:0][63:0] o_x
);
  logic [4:0][63:0] w_c, w_s;
  logic [63:0][4:0] w_sb;

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // constant addition on x2
  always_comb begin
    w_c    = i_x;
    w_c[2] = i_x[2] ^ {56'd0, 4'hF - i_r, i_r};
  end

  for (genvar k = 0; k < 64; k++) begin : g_lane
    asconp_sbox_lane u_lane (
      .i_lut (i_lut),
      .i_col ({w_c[0][k], w_c[1][k], w_c[2][k], w_c[3][k], w_c[4][k]}),
      .o_sb  (w_sb[k])
    );
  end

  // scatter lookup results back into the word lanes
  always_comb begin
    w_s = '0;
    for (int k = 0; k < 64; k++)
      for (int i = 0; i < 5; i++)
        w_s[i][k] = w_sb[k][4-i];
  end

  // linear layer
  always_comb begin
    o_x[0] = w_s[0] ^ ror(w_s[0], 19) ^ ror(w_s[0], 28);
    o_x[1] = w_s[1] ^ ror(w_s[1], 61) ^ ror(w_s[1], 39);
    o_x[2] = w_s[2] ^ ror(w_s[2],  1) ^ ror(w_s[2],  6);
    o_x[3] = w_s[3] ^ ror(w_s[3], 10) ^ ror(w_s[3], 17);
    o_x[4] = w_s[4] ^ ror(w_s[4],  7) ^ ror(w_s[4], 41);
  end
endmodule

module asconp_iter_lut #(
  parameter int               UROL     = 1,
  parameter logic [31:0][4:0] DEF_SBOX = {
    5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
    5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
    5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
    5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04}
) (
  input  logic               clk,
  input  logic               rst_n,
  asconp_iter_lut_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [4:0][63:0]    r_x;
  logic [3:0]          r_rc;
  logic [31:0][4:0]    r_lut;
  logic                r_cfg_err;
  logic                w_accept, w_legal, w_ready, w_valid;
  logic [3:0]          w_rc_nxt;
  logic [UROL:0][4:0][63:0] w_chain;

  assign w_accept = (r_state == S_IDLE) && bus.start_i;
  assign w_legal  = (bus.rounds_i != 4'd0) && (bus.rounds_i <= 4'd12) &&
                    ((32'(bus.rounds_i) % UROL) == 0);
  assign w_rc_nxt = r_rc + 4'(UROL);

  // UROL rounds chained combinationally off the state register
  assign w_chain[0] = r_x;
  for (genvar j = 0; j < UROL; j++) begin : g_rnd
    asconp_round u_round (
      .i_x   (w_chain[j]),
      .i_r   (r_rc + 4'(j)),
      .i_lut (r_lut),
      .o_x   (w_chain[j+1])
    );
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (w_accept && w_legal) w_state_nxt = S_RUN;
      end
      S_RUN:  if (w_rc_nxt == 4'd12) w_state_nxt = S_DONE;
      S_DONE: begin
        w_valid = 1'b1;
        if (bus.out_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // permutation state and round counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_rc <= '0;
    end else if (w_accept && w_legal) begin
      r_x  <= {bus.x4_i, bus.x3_i, bus.x2_i, bus.x1_i, bus.x0_i};
      r_rc <= 4'd12 - bus.rounds_i;
    end else if (r_state == S_RUN) begin
      r_x  <= w_chain[UROL];
      r_rc <= w_rc_nxt;
    end
  end

  // one-cycle pulse for a rejected start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cfg_err <= 1'b0;
    else        r_cfg_err <= w_accept && !w_legal;
  end

  // LUT: reloads defaults on reset, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lut <= DEF_SBOX;
    else if (r_state == S_IDLE && bus.sbox_we_i) r_lut[bus.sbox_addr_i] <= bus.sbox_wdata_i;
  end

  assign bus.ready_o     = w_ready;
  assign bus.out_valid_o = w_valid;
  assign bus.cfg_err_o   = r_cfg_err;
  assign bus.x0_o        = r_x[0];
  assign bus.x1_o        = r_x[1];
  assign bus.x2_o        = r_x[2];
  assign bus.x3_o        = r_x[3];
  assign bus.x4_o        = r_x[4];
`ifdef ASCONP_SBOX_READBACK_EN
  assign bus.sbox_rdata_o = r_lut[bus.sbox_addr_i];
`endif
endmodule

// File: tb/tb_asconp_iter_lut.sv
// Scoreboard bench for asconp_iter_lut: three engines (UROL=1,2,4) share clock/reset.
// Reference model uses the bitsliced Ascon S-box equations, not a table.
module tb_asconp_iter_lut;
  logic clk, rst_n;
  int   cyc = 0;
  int   total = 0, bad = 0;

  logic [2:0]             st, ordy, we, rdy, vld, err;
  logic [2:0][3:0]        rnd;
  logic [2:0][4:0][63:0]  xi, xo;
  logic [2:0][4:0]        wa, wd, rd;
  int                     acc_cyc [3];
  int                     first_cyc [3];
  bit                     pv [3];

  typedef struct {int dut; logic [4:0][63:0] x; int lat;} exp_t;
  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int UR = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    asconp_iter_lut_if bus ();
    assign bus.start_i      = st[g];
    assign bus.rounds_i     = rnd[g];
    assign bus.x0_i         = xi[g][0];
    assign bus.x1_i         = xi[g][1];
    assign bus.x2_i         = xi[g][2];
    assign bus.x3_i         = xi[g][3];
    assign bus.x4_i         = xi[g][4];
    assign bus.out_ready_i  = ordy[g];
    assign bus.sbox_we_i    = we[g];
    assign bus.sbox_addr_i  = wa[g];
    assign bus.sbox_wdata_i = wd[g];
    assign rdy[g] = bus.ready_o;
    assign vld[g] = bus.out_valid_o;
    assign err[g] = bus.cfg_err_o;
    assign xo[g]  = {bus.x4_o, bus.x3_o, bus.x2_o, bus.x1_o, bus.x0_o};
`ifdef ASCONP_SBOX_READBACK_EN
    assign rd[g] = bus.sbox_rdata_o;
`else
    assign rd[g] = 5'd0;
`endif
    asconp_iter_lut #(.UROL(UR)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [4:0][63:0] ref_round(input logic [4:0][63:0] s, input int r, input bit sb);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    a0 = s[0]; a1 = s[1]; a2 = s[2]; a3 = s[3]; a4 = s[4];
    a2 = a2 ^ 64'((15 - r) * 16 + r);
    if (sb) begin
      a0 ^= a4; a4 ^= a3; a2 ^= a1;
      t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
      a0 ^= t1; a1 ^= t2; a2 ^= t3; a3 ^= t4; a4 ^= t0;
      a1 ^= a0; a0 ^= a4; a3 ^= a2; a2 = ~a2;
    end
    a0 = a0 ^ ror(a0, 19) ^ ror(a0, 28);
    a1 = a1 ^ ror(a1, 61) ^ ror(a1, 39);
    a2 = a2 ^ ror(a2,  1) ^ ror(a2,  6);
    a3 = a3 ^ ror(a3, 10) ^ ror(a3, 17);
    a4 = a4 ^ ror(a4,  7) ^ ror(a4, 41);
    return {a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [4:0][63:0] ref_perm(input logic [4:0][63:0] s, input int rounds, input bit sb);
    logic [4:0][63:0] x;
    x = s;
    for (int r = 12 - rounds; r < 12; r++) x = ref_round(x, r, sb);
    return x;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int d, input logic [3:0] r, input logic [4:0][63:0] s,
                       input bit expect_out, input bit sb, input int lat);
    exp_t e;
    st[d] = 1'b1; rnd[d] = r; xi[d] = s;
    step();
    st[d] = 1'b0;
    acc_cyc[d] = cyc;
    if (expect_out) begin
      e.dut = d; e.x = ref_perm(s, int'(r), sb); e.lat = lat;
      q.push_back(e);
    end
  endtask

  // wait for out_valid while checking the engine stays busy; hand off if consumer ready
  task automatic run_wait(input int d);
    int i;
    for (i = 0; i < 40; i++) begin
      if (vld[d]) break;
      chk($sformatf("d%0d_busy_ready", d), 320'(rdy[d]), 320'(0));
      step();
    end
    if (i == 40) begin
      total++; bad++;
      $display("FAIL d%0d_valid_timeout: got valid=0 want valid=1 within 40 cycles", d);
    end else if (ordy[d]) begin
      step();
      chk($sformatf("d%0d_ready_after", d), 320'(rdy[d]), 320'(1));
      chk($sformatf("d%0d_valid_after", d), 320'(vld[d]), 320'(0));
    end
  endtask

  task automatic cfg_reject(input int d, input logic [3:0] r);
    logic [319:0] prev;
    prev = xo[d];
    issue(d, r, {5{64'hdead_beef_0000_0001}}, 1'b0, 1'b1, 0);
    chk($sformatf("d%0d_cfgerr_r%0d", d, r), 320'(err[d]), 320'(1));
    chk($sformatf("d%0d_rej_ready_r%0d", d, r), 320'(rdy[d]), 320'(1));
    chk($sformatf("d%0d_rej_x_r%0d", d, r), xo[d], prev);
    step();
    chk($sformatf("d%0d_cfgerr_clr_r%0d", d, r), 320'(err[d]), 320'(0));
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (vld[g] && !pv[g]) first_cyc[g] = cyc;
        pv[g] = vld[g];
        if (vld[g] && ordy[g]) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL d%0d_unexpected_valid: got valid=1 want no output", g);
          end else begin
            e = q.pop_front();
            chk($sformatf("d%0d_src", g), 320'(g), 320'(e.dut));
            chk($sformatf("d%0d_data", g), xo[g], e.x);
            chk($sformatf("d%0d_latency", g), 320'(first_cyc[g] - acc_cyc[g]), 320'(e.lat));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [4:0][63:0] S_INIT = {64'h08090a0b0c0d0e0f, 64'h0001020304050607,
                                         64'h08090a0b0c0d0e0f, 64'h0001020304050607,
                                         64'h80400c0600000000};
  localparam logic [4:0][63:0] S_A = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                      64'h0f1e2d3c4b5a6978, 64'h8877665544332211,
                                      64'hdeadbeefcafef00d};
  localparam logic [4:0][63:0] S_B = {64'hffffffffffffffff, 64'h0000000000000000,
                                      64'haaaaaaaa55555555, 64'h0000000100000001,
                                      64'h8000000000000001};

  initial begin
    logic [319:0] snap;
    st = '0; ordy = '1; we = '0; rnd = '0; xi = '0; wa = '0; wd = '0;
    for (int g = 0; g < 3; g++) begin acc_cyc[g] = 0; first_cyc[g] = 0; pv[g] = 0; end
    rst_n = 1'b0;
    step(); step();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("d%0d_rst_ready", g), 320'(rdy[g]), 320'(1));
      chk($sformatf("d%0d_rst_valid", g), 320'(vld[g]), 320'(0));
      chk($sformatf("d%0d_rst_err", g), 320'(err[g]), 320'(0));
      chk($sformatf("d%0d_rst_x", g), xo[g], 320'(0));
    end
    rst_n = 1'b1;
    step();

    // UROL=4: illegal round counts rejected, then legal p4/p8/p12
    cfg_reject(2, 4'd6);
    cfg_reject(2, 4'd0);
    cfg_reject(2, 4'd13);
    issue(2, 4'd4, S_A, 1'b1, 1'b1, 1);  run_wait(2);
    issue(2, 4'd8, S_B, 1'b1, 1'b1, 2);  run_wait(2);
    issue(2, 4'd12, S_INIT, 1'b1, 1'b1, 3); run_wait(2);

    // UROL=2: p6 and p8
    issue(1, 4'd6, S_A, 1'b1, 1'b1, 3);  run_wait(1);
    issue(1, 4'd8, S_B, 1'b1, 1'b1, 4);  run_wait(1);

    // UROL=1: p12 on the Ascon-128 init state
    issue(0, 4'd12, S_INIT, 1'b1, 1'b1, 12); run_wait(0);

    // identity LUT, then one round = constant add + linear layer
    for (int k = 0; k < 32; k++) begin
      we[0] = 1'b1; wa[0] = 5'(k); wd[0] = 5'(k);
      step();
    end
    we[0] = 1'b0;
`ifdef ASCONP_SBOX_READBACK_EN
    wa[0] = 5'd5; #1;
    chk("d0_readback", 320'(rd[0]), 320'(5));
`endif
    issue(0, 4'd1, S_A, 1'b1, 1'b0, 1); run_wait(0);

    // reset during the 5th RUN cycle of a p12
    issue(0, 4'd12, S_B, 1'b0, 1'b1, 12);
    step(); step(); step(); step();
    rst_n = 1'b0; #1;
    chk("d0_abort_valid", 320'(vld[0]), 320'(0));
    chk("d0_abort_x", xo[0], 320'(0));
    chk("d0_abort_ready", 320'(rdy[0]), 320'(1));
    step();
    rst_n = 1'b1;
    step();
    // LUT restored to the standard S-box by reset
    issue(0, 4'd12, S_B, 1'b1, 1'b1, 12); run_wait(0);

    // consumer stalls 10 cycles in DONE while start/LUT-write are toggled
    ordy[0] = 1'b0;
    issue(0, 4'd12, S_A, 1'b1, 1'b1, 12); run_wait(0);
    snap = xo[0];
    for (int i = 0; i < 10; i++) begin
      st[0] = i[0]; rnd[0] = 4'd12; xi[0] = S_B;
      we[0] = 1'b1; wa[0] = 5'(i); wd[0] = 5'(~i);
      step();
      chk("d0_hold_x", xo[0], snap);
      chk("d0_hold_valid", 320'(vld[0]), 320'(1));
    end
    st[0] = 1'b0; we[0] = 1'b0; ordy[0] = 1'b1;
    step();
    chk("d0_release_ready", 320'(rdy[0]), 320'(1));
    // LUT writes during DONE must not have landed
    issue(0, 4'd12, S_INIT, 1'b1, 1'b1, 12); run_wait(0);

    begin
      int i;
      for (i = 0; i < 60; i++) begin
        if (q.size() == 0) break;
        step();
      end
      if (q.size() != 0) begin
        total++; bad++;
        $display("FAIL drain: got %0d pending want 0", q.size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/asconp_iter_lut.md
Name: asconp_iter_lut

Overview:
Iterative, parametrised Ascon permutation engine with a runtime-programmable 5-bit S-box LUT.
- Runs Ascon-p with a per-request round count (1..12), evaluating UROL rounds per clock over a registered 320-bit state.
- Start/ready input handshake; valid/ready output handshake.
- Sits between the mode controller (AEAD/hash sequencer) and the state register file, replacing fixed-round combinational permutation instances.

Parameters:
UROL, 1, rounds evaluated per clock; legal values 1, 2, 3, 4, 6.
DEF_SBOX, standard Ascon S-box (32x5 bits, entry 0 = 0x04 … entry 31 = 0x17), LUT contents after reset.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  request; accepted when start_i && ready_o
rounds_i  in  4  round count for this request, sampled on accept
x0_i..x4_i  in  64 each  input state words, sampled on accept
ready_o  out  1  engine idle, can accept start or LUT write
out_valid_o  out  1  result available on x*_o
out_ready_i  in  1  consumer takes result
x0_o..x4_o  out  64 each  state register contents
cfg_err_o  out  1  one-cycle pulse: start rejected for illegal rounds_i
sbox_we_i  in  1  LUT write strobe
sbox_addr_i  in  5  LUT write address
sbox_wdata_i  in  5  LUT write data
sbox_rdata_o  out  5  LUT read data (only with ASCONP_SBOX_READBACK_EN)

Behaviour:
- Reset (async, any time, including mid-permutation):
  - state -> IDLE; ready_o = 1; out_valid_o = 0; cfg_err_o = 0.
  - State registers and x*_o = 0.
  - Round counter = 0.
  - LUT reloads DEF_SBOX.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE, accept (start_i && ready_o):
  - Legal request: rounds_i in 1..12 and rounds_i % UROL == 0.
    - Load x*_i into the state; rc <= 12 - rounds_i; go RUN.
  - Illegal request: no load; cfg_err_o pulses 1 cycle; stay IDLE.
- RUN, each clock:
  - Apply UROL rounds in sequence j = 0..UROL-1 with round index r = rc + j:
    - x2 ^= {56'd0, 4'hF - r, r};
    - substitution: 64 parallel lookups of column {x0[k],x1[k],x2[k],x3[k],x4[k]} (x0 = MSB), each 5-bit result written back to the same bit positions;
    - linear layer with rotation pairs x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
  - rc += UROL.
  - When rc reaches 12, go DONE.
  - Number of RUN cycles N = rounds_i / UROL.
  - out_valid_o rises after the Nth edge following the accept edge.
- DONE:
  - out_valid_o = 1; x*_o stable.
  - On out_valid_o && out_ready_i: go IDLE; ready_o = 1 next cycle.
  - Back-to-back: start_i is accepted no earlier than the cycle after the handoff.
- ready_o = 1 only in IDLE. start_i and sbox_we_i are ignored in RUN and DONE.
- LUT write:
  - Applies in IDLE only: LUT[sbox_addr_i] <= sbox_wdata_i on the clock edge.
  - Writes and start in the same IDLE cycle: the write takes effect, and the permutation uses the updated LUT.
- x*_o always reflects the state register. Mid-run values are not qualified and must be ignored unless out_valid_o = 1.
- rc and round arithmetic are 4-bit; r never exceeds 11 within a legal request.

Optional Feature:
ASCONP_SBOX_READBACK_EN
- Defined:
  - Port sbox_rdata_o exists and equals LUT[sbox_addr_i] combinationally.
  - Readback is valid in any state.
- Undefined:
  - Port absent; the LUT is write-only.
  - No change to any other timing.

Test Plan:
- UROL=1, rounds_i=12, x*_i = Ascon-128 init state -> out_valid_o exactly 12 cycles after accept; x*_o bit-exact vs software Ascon-p12; ready_o = 0 throughout.
- UROL=2, rounds_i=6 and rounds_i=8 -> valid after 3 and 4 cycles respectively; outputs match software p6/p8.
- UROL=4, rounds_i=6; also rounds_i=0 and rounds_i=13 -> cfg_err_o pulses 1 cycle each; ready_o stays 1; x*_o unchanged.
- Write identity LUT (addr k -> data k, 32 writes), then rounds_i=1 -> output equals constant-add plus linear layer only. Reassert rst_n=0, then run p12 -> result matches the standard S-box again.
- Assert rst_n=0 on the 5th RUN cycle of a p12 -> out_valid_o=0, x*_o=0, ready_o=1 immediately. A new request then completes normally in 12 cycles.
- Hold out_ready_i=0 for 10 cycles in DONE while toggling start_i and sbox_we_i -> x*_o stable, no LUT change. Release -> IDLE next cycle.
